// File: rtl/xnorpop_stim_checker.sv
// rtl/xnorpop_stim_checker.sv - stimulus generator and golden XNOR-popcount checker for the 128-bit carry-study adder
module xnorpop_stim_checker #(
    parameter int          WIDTH  = 128,
    parameter int          LANES  = 8,
    parameter int          SETTLE = 2,
    parameter logic [31:0] SEED   = 32'hACE12468
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      num_vec,
    input  logic [1:0]       pat_mode,
    output logic [WIDTH-1:0] inx,
    output logic [WIDTH-1:0] iny,
    input  logic [7:0]       dut_sum,
    output logic             busy,
    output logic             done,
    output logic [15:0]      vec_count,
    output logic [15:0]      err_count,
    output logic             first_err_valid,
    output logic [15:0]      first_err_idx,
    output logic [7:0]       first_err_sum
);

    localparam int          GOLD_CYCLES = WIDTH / LANES;
    localparam logic [31:0] LFSR_MASK   = 32'h80200003;
    // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [31:0] SEED_EFF    = (SEED == 32'h0) ? 32'h1 : SEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SETTLE,
        S_GOLD,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state;
    logic [31:0]      lfsr;
    logic [15:0]      cnt;
    logic [15:0]      num_vec_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] x_work;
    logic [WIDTH-1:0] y_work;
    logic [7:0]       cap_sum;
    logic [7:0]       acc;

    logic [31:0]      lfsr_next;
    logic [WIDTH-1:0] x_final;
    logic [WIDTH-1:0] y_final;
    logic [WIDTH-1:0] y_last;
    logic [WIDTH-1:0] xnor_vec;
    logic [LANES-1:0] slice;
    logic [15:0]      vec_next;

    function automatic logic [7:0] pop_lanes(input logic [LANES-1:0] v);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < LANES; i++) begin
            s = s + 8'(v[i]);
        end
        return s;
    endfunction

    // Next LFSR state, the final operand pair at the end of FILL, and the current golden slice.
    always_comb begin
        lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);
        // The last FILL word lands in the top of Y in the same cycle the operands are published.
        y_last = y_work;
        y_last[WIDTH-32 +: 32] = lfsr;
        case (mode_q)
            2'd1: begin
                x_final = '1;
                y_final = '0;
            end
            2'd2: begin
                x_final = x_work;
                y_final = x_work;
            end
            2'd3: begin
                x_final = '1;
                y_final = '1;
            end
            default: begin
                x_final = x_work;
                y_final = y_last;
            end
        endcase
        xnor_vec = ~(inx ^ iny);
        slice    = LANES'(xnor_vec >> (int'(cnt) * LANES));
        vec_next = vec_count + 16'd1;
    end

    // Run sequencer: fill operands from the LFSR, settle, count golden serially, compare, repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            lfsr            <= SEED_EFF;
            cnt             <= 16'd0;
            num_vec_q       <= 16'd0;
            mode_q          <= 2'd0;
            x_work          <= '0;
            y_work          <= '0;
            cap_sum         <= 8'd0;
            acc             <= 8'd0;
            inx             <= '0;
            iny             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            vec_count       <= 16'd0;
            err_count       <= 16'd0;
            first_err_valid <= 1'b0;
            first_err_idx   <= 16'd0;
            first_err_sum   <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_vec_q       <= num_vec;
                        mode_q          <= pat_mode;
                        vec_count       <= 16'd0;
                        err_count       <= 16'd0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= 16'd0;
                        first_err_sum   <= 8'd0;
                        cnt             <= 16'd0;
                        if (num_vec == 16'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FILL;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    lfsr <= lfsr_next;
                    if (cnt == 16'd7) begin
                        x_work <= x_final;
                        y_work <= y_final;
                        inx    <= x_final;
                        iny    <= y_final;
                        cnt    <= 16'd0;
                        state  <= S_SETTLE;
                    end else begin
                        if (!cnt[2]) begin
                            x_work[{cnt[1:0], 5'b00000} +: 32] <= lfsr;
                        end else begin
                            y_work[{cnt[1:0], 5'b00000} +: 32] <= lfsr;
                        end
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == 16'(SETTLE - 1)) begin
                        cap_sum <= dut_sum;
                        acc     <= 8'd0;
                        cnt     <= 16'd0;
                        state   <= S_GOLD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_GOLD: begin
                    acc <= acc + pop_lanes(slice);
                    if (cnt == 16'(GOLD_CYCLES - 1)) begin
                        cnt   <= 16'd0;
                        state <= S_COMPARE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_COMPARE: begin
                    vec_count <= vec_next;
                    if (cap_sum != acc) begin
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'd1;
                        end
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_idx   <= vec_count;
                            first_err_sum   <= cap_sum;
                        end
                    end
                    if (vec_next < num_vec_q) begin
                        state <= S_FILL;
                    end else begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
